dpram_fifo_ctrl: RTL
====================

# dpram_fifo_ctrl

Synchronous FIFO controller that sits directly in front of the 16x8 dual-port RAM and turns it into a 16-entry, 8-bit first-in/first-out buffer. Port A of the RAM is the write port and port B is the read port. This block owns the read/write pointers, occupancy count and full/empty flags, and qualifies the RAM's registered read data with a valid strobe. Both RAM clocks are driven from the single `clk` of this block.

## Interface
- DATA_W, 8, data width; matches the RAM word width.
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W = 16.
- clk  input  1  single clock; drives the RAM's clka and clkb.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_W  write data.
- full  output  1  FIFO holds 16 entries.
- rd_en  input  1  read request.
- rd_data  output  DATA_W  read data; meaningful only while rd_valid=1.
- rd_valid  output  1  rd_data holds the word popped in the previous cycle.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_W+1  occupancy, 0..16.
- overflow  output  1  one-cycle pulse: write requested while full.
- underflow  output  1  one-cycle pulse: read requested while empty.
- ram_we_a  output  1  to RAM weA.
- ram_addr_a  output  ADDR_W  to RAM addra.
- ram_din_a  output  DATA_W  to RAM din_a.
- ram_we_b  output  1  to RAM weB; tied 0.
- ram_addr_b  output  ADDR_W  to RAM addrb.
- ram_dout_b  input  DATA_W  from RAM dout_b; registered in the RAM, 1-cycle latency.

## Operation
- Pointers: wptr and rptr are (ADDR_W+1)-bit registers. The low ADDR_W bits address the RAM. The MSB is a wrap bit.
- Flag equations:
  - empty = (wptr == rptr).
  - full = (low bits equal) && (MSBs differ).
  - count = wptr - rptr, modulo 2**(ADDR_W+1).
- Write accept: wr_acc = wr_en && !full.
  - ram_we_a = wr_acc (combinational).
  - ram_addr_a = wptr[ADDR_W-1:0].
  - ram_din_a = wr_data.
  - wptr increments on the clock edge.
- Read accept: rd_acc = rd_en && !empty.
  - ram_addr_b = rptr[ADDR_W-1:0] at all times.
  - rptr increments on the edge.
  - rd_valid <= rd_acc.
  - rd_data = ram_dout_b (pass-through).
- Flags use the pre-edge state. There is no fall-through:
  - A write into an empty FIFO can be read no earlier than the next cycle.
  - A read while full frees a slot for writing no earlier than the next cycle.
- Simultaneous events:
  - Accepted read and write in the same cycle: count is unchanged; both pointers advance.
  - Full with wr_en && rd_en: read accepted, write rejected, overflow pulses.
  - Empty with both requests: write accepted, read rejected, underflow pulses.
- No same-address collision: port A and port B addresses are equal only when empty (no read is accepted) or full (no write is accepted).
- Wrap-around: pointers wrap from 31 to 0. The RAM address wraps from 15 to 0.
- overflow <= wr_en && full; underflow <= rd_en && empty. Both are registered single-cycle pulses and are not sticky.
- Reset (asynchronous, any time, including mid-burst):
  - wptr=0, rptr=0, rd_valid=0, overflow=0, underflow=0.
  - Therefore empty=1, full=0, count=0.
  - A read in flight is discarded.
  - RAM contents are not cleared.
- Reset values of combinational outputs while rst_n=0: ram_we_a=0 only if wr_en=0; ram_addr_a=0, ram_addr_b=0; ram_we_b=0.

## Timing
- Write latency: the word is stored at the edge that accepts it. It is readable starting the following cycle (empty deasserts 1 cycle after the write).
- Read latency: rd_en accepted at edge N, so rd_valid=1 and rd_data is valid in cycle N+1, for one cycle.
- Back-to-back reads yield one word per cycle. rd_valid stays high continuously.
- Flags and count update 1 cycle after the accepting edge.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset, then write 0xAA with wr_en for 1 cycle → count=1 and empty=0 next cycle. rd_en for 1 cycle → rd_valid=1 with rd_data=0xAA one cycle later, then empty=1.
- Write 0x00..0x0F (16 writes) → full=1, count=16. A 17th write of 0xFF → overflow pulses 1 cycle; RAM is not written (ram_we_a=0).
- From full, read 16 words → data sequence 0x00..0x0F in order, rd_valid high for 16 consecutive cycles, then empty=1. A 17th rd_en → underflow pulses, rd_valid=0.
- Fill 10 entries, then assert wr_en and rd_en together for 20 cycles → count stays 10. Pointers wrap past address 15; output order is preserved across the wrap.
- At full, assert wr_en=1 and rd_en=1 with wr_data=0x55 → read accepted, write rejected, count=15, overflow=1. Next cycle, write 0x55 → accepted, count=16.
- Mid-burst with 5 entries and rd_en high, pull rst_n low asynchronously (between edges) → count=0, empty=1 and rd_valid=0 immediately. After release, a write of 0x66 followed by a read returns 0x66.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - pointer/flag controller turning a 16x8 dual-port RAM into a FIFO
// Port A writes, port B reads; RAM read data is registered, so rd_valid trails the pop by one cycle.
module dpram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_dout_b
);

  // Extra MSB on each pointer distinguishes full from empty when the RAM addresses match.
  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;
  logic            wr_acc;
  logic            rd_acc;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign count  = wptr - rptr;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  assign ram_we_a   = wr_acc;
  assign ram_addr_a = wptr[ADDR_W-1:0];
  assign ram_din_a  = wr_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rptr[ADDR_W-1:0];
  assign rd_data    = ram_dout_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      rd_valid  <= rd_acc;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

endmodule
